memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Y86-64 pipeline M stage plus the M/W pipeline register, directly upstream of write-back.
//  Holds a byte-addressed data memory and performs the loads and stores for
//  rmmovq, mrmovq, pushq, popq, call and ret.
//  Raises the address-error status and registers W_icode, W_stat, W_valE, W_valM,
//  W_dstE and W_dstM for the write-back stage.
//  Exposes m_valM and m_stat combinationally for forwarding and pipeline control.
// PARAMETERS
//  MEM_BYTES  1024  data memory size in bytes; legal addresses are 0..MEM_BYTES-8 for one 8-byte access
// PORTS
//  clk       in   1   clock; every update happens on posedge
//  rst_n     in   1   synchronous active-low reset
//  M_stat    in   4   status from E/M register: 1=AOK 2=HLT 3=ADR 4=INS
//  M_icode   in   4   instruction code
//  M_valE    in   64  ALU result; address for rmmovq/mrmovq/pushq/call
//  M_valA    in   64  store data (valP for call); address for popq/ret
//  M_dstE    in   4   E destination register; 0xF = none
//  M_dstM    in   4   M destination register; 0xF = none
//  W_stall   in   1   hold the M/W register
//  W_bubble  in   1   load a bubble into the M/W register
//  m_valM    out  64  combinational load data
//  m_stat    out  4   combinational stage status
//  W_stat    out  4   registered status
//  W_icode   out  4   registered icode
//  W_valE    out  64  registered valE
//  W_valM    out  64  registered valM
//  W_dstE    out  4   registered dstE
//  W_dstM    out  4   registered dstM
// BEHAVIOUR
//  Address select:
//   - M_valE for icode 4, 5, A, 8.
//   - M_valA for icode B, 9.
//   - No access for any other icode.
//  Read: icode 5, B, 9. Write: icode 4, A, 8; write data is M_valA.
//  Byte order: little-endian. Byte addr holds bits [7:0]; byte addr+7 holds bits [63:56].
//  dmem_error: an access (read or write) with addr > MEM_BYTES-8.
//   - Compare as unsigned 64-bit.
//   - No wrap: 64'hFFFF_FFFF_FFFF_FFFC is an error.
//  Read path is combinational:
//   - m_valM = memory word on a valid read.
//   - m_valM = 0 when there is no read or dmem_error.
//  m_stat = 3 (ADR) if dmem_error, otherwise M_stat.
//  Write commit:
//   - Happens on posedge when write icode && !dmem_error && M_stat==1 && rst_n.
//   - All 8 bytes update together; a faulting write changes no byte.
//   - Independent of W_stall/W_bubble; upstream control bubbles M when a store must be cancelled.
//  Read during write: the combinational read sees the pre-edge contents; new data is visible the cycle after the edge.
//  Memory contents are not affected by rst_n and initialise to zero at time 0.
//  M/W register, in priority order at posedge:
//   1. !rst_n: bubble.
//   2. W_stall: hold all W_* values (stall wins over bubble).
//   3. W_bubble: bubble.
//   4. Otherwise load W_stat=m_stat, W_icode=M_icode, W_valE=M_valE, W_valM=m_valM, W_dstE=M_dstE, W_dstM=M_dstM.
//  Bubble / reset values: W_stat=1, W_icode=1 (nop), W_valE=0, W_valM=0, W_dstE=0xF, W_dstM=0xF.
//  Latency: one cycle from M_* inputs to W_* outputs; zero cycles to m_valM and m_stat.
//  Reset in mid-operation: a write presented in the reset cycle is dropped, and the register bubbles.
// TESTING
//  T1 rmmovq M_icode=4 M_valE=0x100 M_valA=0x1122334455667788, then mrmovq M_icode=5 M_valE=0x100 M_dstM=3
//     -> byte 0x100=0x88, byte 0x107=0x11; m_valM=0x1122334455667788; next cycle W_valM equal, W_dstM=3, W_stat=1.
//  T2 boundary read, MEM_BYTES=1024: mrmovq M_valE=1016 -> no error.
//     mrmovq M_valE=1017 -> m_stat=3, m_valM=0, W_stat=3 next cycle.
//     rmmovq to 1017 -> no memory byte changes.
//  T3 pushq M_icode=A M_valE=0x1F8 M_valA=0xABCD, then popq M_icode=B M_valA=0x1F8 M_dstM=2 M_valE=0x200
//     -> m_valM=0xABCD; W_valE=0x200; W_dstM=2.
//  T4 W_stall=1 for 2 cycles with changing M_* inputs -> W_* outputs frozen.
//     W_stall=1 and W_bubble=1 together -> W_* outputs still frozen.
//     W_bubble=1 alone -> W_icode=1, W_dstE=0xF, W_dstM=0xF.
//  T5 rst_n=0 during an rmmovq to 0x80 with data 0x55 -> byte 0x80 keeps its old value; all W_* take bubble values.
//     Release rst_n -> normal loading resumes the next edge.
//  T6 rmmovq with M_stat=4 (INS) -> no memory write; W_stat=4.
//     Then mrmovq to the same address the cycle after a write -> returns the newly written data.

Source files
------------

// File: rtl/memory_stage.sv
// Y86-64 memory stage with the M/W pipeline register.
// Byte-addressed little-endian data memory, combinational read path for
// forwarding, posedge write commit, and the registered W_* outputs.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h3;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  logic [7:0]    r_mem [MEM_BYTES];

  logic [63:0]   w_addr;
  logic          w_rd;
  logic          w_wr;
  logic          w_err;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_word;

  logic [3:0]    r_stat;
  logic [3:0]    r_icode;
  logic [63:0]   r_vale;
  logic [63:0]   r_valm;
  logic [3:0]    r_dste;
  logic [3:0]    r_dstm;

  // Decode access type and pick the address source from the icode.
  always_comb begin
    w_addr = 64'd0;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    case (M_icode)
      I_RMMOVQ: begin w_addr = M_valE; w_wr = 1'b1; end
      I_MRMOVQ: begin w_addr = M_valE; w_rd = 1'b1; end
      I_CALL:   begin w_addr = M_valE; w_wr = 1'b1; end
      I_PUSHQ:  begin w_addr = M_valE; w_wr = 1'b1; end
      I_RET:    begin w_addr = M_valA; w_rd = 1'b1; end
      I_POPQ:   begin w_addr = M_valA; w_rd = 1'b1; end
      default:  begin w_addr = 64'd0; end
    endcase
  end

  // Full 64-bit unsigned compare so huge addresses never wrap into range.
  assign w_err    = (w_rd || w_wr) && (w_addr > ADDR_MAX);
  assign w_idx    = w_addr[AW-1:0];
  assign w_commit = w_wr && !w_err && (M_stat == STAT_AOK) && rst_n;

  // Assemble the little-endian word from eight consecutive bytes.
  always_comb begin
    w_word = 64'd0;
    for (int k = 0; k < 8; k++) begin
      w_word[8*k +: 8] = r_mem[w_idx + AW'(k)];
    end
  end

  assign m_valM = (w_rd && !w_err) ? w_word : 64'd0;
  assign m_stat = w_err ? STAT_ADR : M_stat;

  // Commit all eight bytes of a store together; pipeline stall/bubble has no say here.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[w_idx + AW'(k)] <= M_valA[8*k +: 8];
      end
    end
  end

  // M/W register: reset and bubble insert a nop, stall takes priority over bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || (W_bubble && !W_stall)) begin
      r_stat  <= STAT_AOK;
      r_icode <= I_NOP;
      r_vale  <= 64'd0;
      r_valm  <= 64'd0;
      r_dste  <= REG_NONE;
      r_dstm  <= REG_NONE;
    end else if (!W_stall) begin
      r_stat  <= m_stat;
      r_icode <= M_icode;
      r_vale  <= M_valE;
      r_valm  <= m_valM;
      r_dste  <= M_dstE;
      r_dstm  <= M_dstM;
    end
  end

  assign W_stat  = r_stat;
  assign W_icode = r_icode;
  assign W_valE  = r_vale;
  assign W_valM  = r_valm;
  assign W_dstE  = r_dste;
  assign W_dstM  = r_dstm;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by random traffic,
// all checked against a byte-array reference model of the stage.
module tb_memory_stage;

  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic        W_stall, W_bubble;
  logic [63:0] m_valM, W_valE, W_valM;
  logic [3:0]  m_stat, W_stat, W_icode, W_dstE, W_dstM;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  mm [MEM];
  logic [3:0]  e_stat, e_icode, e_dste, e_dstm;
  logic [63:0] e_vale, e_valm;
  logic [63:0] last_mvalm;
  logic [3:0]  last_mstat;

  memory_stage #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .m_valM(m_valM), .m_stat(m_stat),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [63:0] a);
    logic [63:0] v = 64'd0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mm[int'(a[9:0]) + k];
    return v;
  endfunction

  // One clock: drive inputs, check the combinational outputs, clock, check W_*.
  task automatic step(input logic [3:0] st, input logic [3:0] ic,
                      input logic [63:0] ve, input logic [63:0] va,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic stl, input logic bub, input logic rn);
    logic        rd, wr, err;
    logic [63:0] a, ev;
    logic [3:0]  es;
    M_stat = st; M_icode = ic; M_valE = ve; M_valA = va;
    M_dstE = de; M_dstM = dm; W_stall = stl; W_bubble = bub; rst_n = rn;
    #2;
    rd  = ic inside {4'h5, 4'h9, 4'hB};
    wr  = ic inside {4'h4, 4'h8, 4'hA};
    a   = (ic inside {4'h9, 4'hB}) ? va : ve;
    err = (rd || wr) && (a > 64'(MEM - 8));
    ev  = (rd && !err) ? mread(a) : 64'd0;
    es  = err ? 4'd3 : st;
    chk("m_valM", m_valM, ev);
    chk("m_stat", {60'd0, m_stat}, {60'd0, es});
    last_mvalm = m_valM;
    last_mstat = m_stat;
    @(posedge clk);
    if (wr && !err && st == 4'd1 && rn)
      for (int k = 0; k < 8; k++) mm[int'(a[9:0]) + k] = va[8*k +: 8];
    if (!rn || (bub && !stl)) begin
      e_stat = 4'd1; e_icode = 4'd1; e_vale = 64'd0; e_valm = 64'd0;
      e_dste = 4'hF; e_dstm = 4'hF;
    end else if (!stl) begin
      e_stat = es; e_icode = ic; e_vale = ve; e_valm = ev; e_dste = de; e_dstm = dm;
    end
    #1;
    chk("W_stat",  {60'd0, W_stat},  {60'd0, e_stat});
    chk("W_icode", {60'd0, W_icode}, {60'd0, e_icode});
    chk("W_valE",  W_valE, e_vale);
    chk("W_valM",  W_valM, e_valm);
    chk("W_dstE",  {60'd0, W_dstE},  {60'd0, e_dste});
    chk("W_dstM",  {60'd0, W_dstM},  {60'd0, e_dstm});
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 64'd1016;
      1:       return 64'd1017 + 64'($urandom_range(0, 10));
      2:       return 64'hFFFF_FFFF_FFFF_FFFC;
      3:       return {$urandom, $urandom};
      4:       return 64'($urandom_range(0, 1016));
      default: return 64'($urandom_range(0, 15) * 8 + 64'h100);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < MEM; i++) mm[i] = 8'h00;
    e_stat = 4'd1; e_icode = 4'd1; e_vale = 64'd0; e_valm = 64'd0;
    e_dste = 4'hF; e_dstm = 4'hF;
    M_stat = 4'd1; M_icode = 4'd1; M_valE = 64'd0; M_valA = 64'd0;
    M_dstE = 4'hF; M_dstM = 4'hF; W_stall = 1'b0; W_bubble = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;

    // reset
    step(4'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0, 0);
    chk("rst_icode", {60'd0, W_icode}, 64'd1);
    chk("rst_dstM",  {60'd0, W_dstM},  64'hF);

    // T1 store then load
    step(4'd1, 4'h4, 64'h100, 64'h1122334455667788, 4'hF, 4'hF, 0, 0, 1);
    step(4'd1, 4'h5, 64'h100, 64'd0, 4'hF, 4'd3, 0, 0, 1);
    chk("t1_mvalm", last_mvalm, 64'h1122334455667788);
    chk("t1_wvalm", W_valM, 64'h1122334455667788);
    chk("t1_wdstm", {60'd0, W_dstM}, 64'd3);
    step(4'd1, 4'h5, 64'h107, 64'd0, 4'hF, 4'd4, 0, 0, 1);
    chk("t1_byte107", last_mvalm, 64'h11);

    // T2 boundary
    step(4'd1, 4'h5, 64'd1016, 64'd0, 4'hF, 4'd1, 0, 0, 1);
    chk("t2_1016_stat", {60'd0, last_mstat}, 64'd1);
    step(4'd1, 4'h5, 64'd1017, 64'd0, 4'hF, 4'd1, 0, 0, 1);
    chk("t2_1017_stat", {60'd0, last_mstat}, 64'd3);
    chk("t2_1017_W",    {60'd0, W_stat}, 64'd3);
    step(4'd1, 4'h4, 64'd1017, 64'hDEAD_BEEF_CAFE_F00D, 4'hF, 4'hF, 0, 0, 1);
    step(4'd1, 4'h5, 64'd1016, 64'd0, 4'hF, 4'd1, 0, 0, 1);
    chk("t2_nowrite", last_mvalm, 64'd0);
    step(4'd1, 4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 4'hF, 4'hF, 0, 0, 1);
    chk("t2_wrap", {60'd0, W_stat}, 64'd3);

    // T3 push / pop
    step(4'd1, 4'hA, 64'h1F8, 64'hABCD, 4'd4, 4'hF, 0, 0, 1);
    step(4'd1, 4'hB, 64'h200, 64'h1F8, 4'd4, 4'd2, 0, 0, 1);
    chk("t3_mvalm", last_mvalm, 64'hABCD);
    chk("t3_wvale", W_valE, 64'h200);

    // T4 stall, stall+bubble, bubble
    step(4'd1, 4'h6, 64'h1234, 64'd0, 4'd5, 4'hF, 0, 0, 1);
    step(4'd1, 4'h5, 64'h100, 64'd0, 4'hF, 4'd7, 1, 0, 1);
    step(4'd2, 4'h2, 64'h9999, 64'd5, 4'd8, 4'hF, 1, 0, 1);
    chk("t4_stall_vale", W_valE, 64'h1234);
    step(4'd1, 4'h5, 64'h108, 64'd0, 4'hF, 4'd9, 1, 1, 1);
    chk("t4_stallbub_dste", {60'd0, W_dstE}, 64'd5);
    step(4'd1, 4'h5, 64'h108, 64'd0, 4'hF, 4'd9, 0, 1, 1);
    chk("t4_bub_icode", {60'd0, W_icode}, 64'd1);

    // T5 reset drops a write
    step(4'd1, 4'h4, 64'h80, 64'h77, 4'hF, 4'hF, 0, 0, 1);
    step(4'd1, 4'h4, 64'h80, 64'h55, 4'hF, 4'hF, 0, 0, 0);
    chk("t5_rst_icode", {60'd0, W_icode}, 64'd1);
    step(4'd1, 4'h5, 64'h80, 64'd0, 4'hF, 4'd6, 0, 0, 1);
    chk("t5_keep", last_mvalm, 64'h77);
    chk("t5_resume", {60'd0, W_dstM}, 64'd6);

    // T6 faulting status blocks store; read-after-write
    step(4'd4, 4'h4, 64'h40, 64'h3333, 4'hF, 4'hF, 0, 0, 1);
    chk("t6_wstat", {60'd0, W_stat}, 64'd4);
    step(4'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'd1, 0, 0, 1);
    chk("t6_nowrite", last_mvalm, 64'd0);
    step(4'd1, 4'h4, 64'h40, 64'h0BAD_F00D_1234_5678, 4'hF, 4'hF, 0, 0, 1);
    step(4'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'd1, 0, 0, 1);
    chk("t6_raw", last_mvalm, 64'h0BAD_F00D_1234_5678);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [3:0]  ic, st;
      logic [63:0] ve, va;
      case ($urandom_range(0, 7))
        0: ic = 4'h4;  1: ic = 4'h5;  2: ic = 4'h8;  3: ic = 4'h9;
        4: ic = 4'hA;  5: ic = 4'hB;  6: ic = 4'h5;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      st = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      ve = rand_addr();
      va = (ic inside {4'h9, 4'hB}) ? rand_addr() : {$urandom, $urandom};
      step(st, ic, ve, va, 4'($urandom), 4'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 29) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
